// File: rtl/request_scheduler.sv
// Serves one tracker entry at a time. Row hits win unless an entry is starving by age.
// Drives PRE/ACT/RD/WR on the DRAM command bus and keeps an open row per bank.
module request_scheduler #(
   parameter int unsigned NUM_ENT    = 16,
   parameter int unsigned AGE_THRESH = 8,
   parameter int unsigned T_RP       = 4,
   parameter int unsigned T_RCD      = 4,
   parameter int unsigned T_WR       = 6
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_ENT*69-1:0]   ent_flat,
   input  logic [NUM_ENT-1:0]      valid_vec,
   input  logic [NUM_ENT*6-1:0]    age_flat,
   input  logic [31:0]             dram_rdata,
   input  logic                    dram_rdata_valid,
   output logic                    cmd_valid,
   output logic [2:0]              cmd,
   output logic [1:0]              cmd_bank,
   output logic [15:0]             cmd_row,
   output logic [9:0]              cmd_col,
   output logic [31:0]             cmd_wdata,
   output logic [34:0]             completed_entry,
   output logic                    completed_ctrl,
   output logic                    resp_valid,
   output logic [1:0]              resp_cpu,
   output logic [31:0]             resp_data
);
   localparam int unsigned IdxW      = $clog2(NUM_ENT);
   localparam logic [5:0]  AgeThresh = 6'(AGE_THRESH);
   localparam logic [3:0]  CntRp     = 4'(T_RP - 1);
   localparam logic [3:0]  CntRcd    = 4'(T_RCD - 1);
   localparam logic [3:0]  CntWr     = 4'(T_WR - 1);
   localparam logic [2:0]  CmdNop = 3'd0, CmdAct = 3'd1, CmdRd = 3'd2, CmdWr = 3'd3, CmdPre = 3'd4;

   typedef enum logic [2:0] {StIdle, StPre, StAct, StRw, StWait, StDone} state_e;

   state_e             state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [68:0]        ent_q, ent_d;
   logic [3:0]         bank_open_q, bank_open_d;
   logic [3:0][15:0]   open_row_q, open_row_d;

   logic               cmd_valid_q, cmd_valid_d;
   logic [2:0]         cmd_q, cmd_d;
   logic [1:0]         cmd_bank_q, cmd_bank_d;
   logic [15:0]        cmd_row_q, cmd_row_d;
   logic [9:0]         cmd_col_q, cmd_col_d;
   logic [31:0]        cmd_wdata_q, cmd_wdata_d;
   logic [34:0]        comp_entry_q, comp_entry_d;
   logic               comp_ctrl_q, comp_ctrl_d;
   logic               resp_valid_q, resp_valid_d;
   logic [1:0]         resp_cpu_q, resp_cpu_d;
   logic [31:0]        resp_data_q, resp_data_d;

   logic [68:0]        ent_arr [NUM_ENT];
   logic [5:0]         age_arr [NUM_ENT];
   logic [NUM_ENT-1:0] hit_vec;
   logic               sel_found;
   logic [IdxW-1:0]    sel_idx;
   logic [5:0]         best_age;

   always_comb begin
      for (int i = 0; i < NUM_ENT; i++) begin
         ent_arr[i] = ent_flat[69*i +: 69];
         age_arr[i] = age_flat[6*i +: 6];
         hit_vec[i] = bank_open_q[ent_arr[i][46:45]] &&
                      (open_row_q[ent_arr[i][46:45]] == ent_arr[i][62:47]);
      end
   end

   // Three-tier pick: starving oldest, then lowest-index row hit, then oldest overall.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      best_age  = '0;
      for (int i = 0; i < NUM_ENT; i++) begin
         if (valid_vec[i] && age_arr[i] >= AgeThresh && (!sel_found || age_arr[i] > best_age)) begin
            sel_found = 1'b1;
            sel_idx   = IdxW'(i);
            best_age  = age_arr[i];
         end
      end
      for (int i = 0; i < NUM_ENT; i++) begin
         if (!sel_found && valid_vec[i] && hit_vec[i]) begin
            sel_found = 1'b1;
            sel_idx   = IdxW'(i);
         end
      end
      for (int i = 0; i < NUM_ENT; i++) begin
         if (!(sel_found && (hit_vec[sel_idx] || best_age >= AgeThresh)) && valid_vec[i] &&
             (!sel_found || age_arr[i] > best_age)) begin
            sel_found = 1'b1;
            sel_idx   = IdxW'(i);
            best_age  = age_arr[i];
         end
      end
   end

   logic [68:0] cur_ent;
   logic [1:0]  cur_bank;
   logic [15:0] cur_row;
   logic        cur_hit;
   logic        unused_rsv;
   assign cur_ent    = (state_q == StIdle) ? ent_arr[sel_idx] : ent_q;
   assign cur_bank   = cur_ent[46:45];
   assign cur_row    = cur_ent[62:47];
   assign cur_hit    = bank_open_q[cur_bank] && (open_row_q[cur_bank] == cur_row);
   assign unused_rsv = cur_ent[65];

   always_comb begin
      logic go_act, go_rw, go_done;
      state_d      = state_q;
      cnt_d        = cnt_q;
      ent_d        = ent_q;
      bank_open_d  = bank_open_q;
      open_row_d   = open_row_q;
      cmd_valid_d  = 1'b0;
      cmd_d        = CmdNop;
      cmd_bank_d   = '0;
      cmd_row_d    = '0;
      cmd_col_d    = '0;
      cmd_wdata_d  = '0;
      comp_entry_d = '0;
      comp_ctrl_d  = 1'b0;
      resp_valid_d = 1'b0;
      resp_cpu_d   = '0;
      resp_data_d  = '0;
      go_act       = 1'b0;
      go_rw        = 1'b0;
      go_done      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (sel_found) begin
               ent_d = cur_ent;
               if (cur_hit) begin
                  go_rw = 1'b1;
               end else if (bank_open_q[cur_bank]) begin
                  state_d     = StPre;
                  cnt_d       = CntRp;
                  cmd_valid_d = 1'b1;
                  cmd_d       = CmdPre;
                  cmd_bank_d  = cur_bank;
               end else begin
                  go_act = 1'b1;
               end
            end
         end
         StPre: begin
            if (cnt_q == 4'd0) begin
               bank_open_d[cur_bank] = 1'b0;
               go_act                = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StAct: begin
            if (cnt_q == 4'd0) begin
               bank_open_d[cur_bank] = 1'b1;
               open_row_d[cur_bank]  = cur_row;
               go_rw                 = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StRw: begin
            state_d = StWait;
            cnt_d   = CntWr;
         end
         StWait: begin
            if (cur_ent[66]) begin
               if (cnt_q == 4'd0) go_done = 1'b1;
               else cnt_d = cnt_q - 4'd1;
            end else if (dram_rdata_valid) begin
               go_done = 1'b1;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
      if (go_act) begin
         state_d     = StAct;
         cnt_d       = CntRcd;
         cmd_valid_d = 1'b1;
         cmd_d       = CmdAct;
         cmd_bank_d  = cur_bank;
         cmd_row_d   = cur_row;
      end
      if (go_rw) begin
         state_d     = StRw;
         cmd_valid_d = 1'b1;
         cmd_d       = cur_ent[66] ? CmdWr : CmdRd;
         cmd_bank_d  = cur_bank;
         cmd_col_d   = cur_ent[44:35];
         cmd_wdata_d = cur_ent[66] ? cur_ent[31:0] : 32'd0;
      end
      if (go_done) begin
         state_d      = StDone;
         comp_ctrl_d  = 1'b1;
         comp_entry_d = {cur_ent[68:67], cur_ent[64:32]};
         if (!cur_ent[66]) begin
            resp_valid_d = 1'b1;
            resp_cpu_d   = cur_ent[68:67];
            resp_data_d  = dram_rdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         ent_q        <= '0;
         bank_open_q  <= '0;
         open_row_q   <= '0;
         cmd_valid_q  <= 1'b0;
         cmd_q        <= CmdNop;
         cmd_bank_q   <= '0;
         cmd_row_q    <= '0;
         cmd_col_q    <= '0;
         cmd_wdata_q  <= '0;
         comp_entry_q <= '0;
         comp_ctrl_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_cpu_q   <= '0;
         resp_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         ent_q        <= ent_d;
         bank_open_q  <= bank_open_d;
         open_row_q   <= open_row_d;
         cmd_valid_q  <= cmd_valid_d;
         cmd_q        <= cmd_d;
         cmd_bank_q   <= cmd_bank_d;
         cmd_row_q    <= cmd_row_d;
         cmd_col_q    <= cmd_col_d;
         cmd_wdata_q  <= cmd_wdata_d;
         comp_entry_q <= comp_entry_d;
         comp_ctrl_q  <= comp_ctrl_d;
         resp_valid_q <= resp_valid_d;
         resp_cpu_q   <= resp_cpu_d;
         resp_data_q  <= resp_data_d;
      end
   end

   assign cmd_valid       = cmd_valid_q;
   assign cmd             = cmd_q;
   assign cmd_bank        = cmd_bank_q;
   assign cmd_row         = cmd_row_q;
   assign cmd_col         = cmd_col_q;
   assign cmd_wdata       = cmd_wdata_q;
   assign completed_entry = comp_entry_q;
   assign completed_ctrl  = comp_ctrl_q;
   assign resp_valid      = resp_valid_q;
   assign resp_cpu        = resp_cpu_q;
   assign resp_data       = resp_data_q;
endmodule

// File: tb/tb_request_scheduler.sv
// Bench for request_scheduler: directed scenarios plus random tables, each transaction
// expanded into a per-cycle expected bus trace from the selection and bank rules.
module tb_request_scheduler;
   localparam int NumEnt = 16;
   localparam int TRp = 4, TRcd = 4, TWr = 6;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NumEnt*69-1:0] ent_flat;
   logic [NumEnt-1:0]    valid_vec;
   logic [NumEnt*6-1:0]  age_flat;
   logic [31:0]          dram_rdata;
   logic                 dram_rdata_valid;
   logic                 cmd_valid;
   logic [2:0]           cmd;
   logic [1:0]           cmd_bank;
   logic [15:0]          cmd_row;
   logic [9:0]           cmd_col;
   logic [31:0]          cmd_wdata;
   logic [34:0]          completed_entry;
   logic                 completed_ctrl;
   logic                 resp_valid;
   logic [1:0]           resp_cpu;
   logic [31:0]          resp_data;

   request_scheduler dut (
      .clk(clk), .reset(reset), .ent_flat(ent_flat), .valid_vec(valid_vec),
      .age_flat(age_flat), .dram_rdata(dram_rdata), .dram_rdata_valid(dram_rdata_valid),
      .cmd_valid(cmd_valid), .cmd(cmd), .cmd_bank(cmd_bank), .cmd_row(cmd_row),
      .cmd_col(cmd_col), .cmd_wdata(cmd_wdata), .completed_entry(completed_entry),
      .completed_ctrl(completed_ctrl), .resp_valid(resp_valid), .resp_cpu(resp_cpu),
      .resp_data(resp_data)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        cv;
      logic [2:0]  cmd;
      logic [1:0]  bank;
      logic [15:0] row;
      logic [9:0]  col;
      logic [31:0] wd;
      logic        cc;
      logic [34:0] ce;
      logic        rv;
      logic [1:0]  rc;
      logic [31:0] rd;
   } exp_t;

   int total = 0;
   int bad   = 0;

   logic [68:0] tbl_ent [NumEnt];
   logic [5:0]  tbl_age [NumEnt];
   logic [15:0] tbl_vld;
   logic        m_open [4];
   logic [15:0] m_row  [4];

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_cycle(input exp_t e, input int t);
      check_eq($sformatf("cmd@%0d", t), {cmd_valid, cmd, cmd_bank, cmd_row, cmd_col, cmd_wdata},
               {e.cv, e.cmd, e.bank, e.row, e.col, e.wd});
      check_eq($sformatf("cmpl@%0d", t), 64'({completed_ctrl, completed_entry}), 64'({e.cc, e.ce}));
      check_eq($sformatf("resp@%0d", t), 64'({resp_valid, resp_cpu, resp_data}),
               64'({e.rv, e.rc, e.rd}));
   endtask

   function automatic logic [68:0] mk(input logic [1:0] cpu, input logic we, input logic [1:0] bank,
                                      input logic [15:0] row, input logic [9:0] col,
                                      input logic [31:0] wd);
      logic [32:0] addr;
      addr = {2'b00, row, bank, col, 3'b000};
      return {cpu, we, 1'b0, addr, wd};
   endfunction

   function automatic logic is_hit(input int i);
      logic [1:0] b;
      b = tbl_ent[i][46:45];
      return m_open[b] && (m_row[b] == tbl_ent[i][62:47]);
   endfunction

   // Starving entries (age >= 8) by oldest, else first row hit, else oldest; ties to low index.
   function automatic int pick();
      int best = -1;
      for (int i = 0; i < NumEnt; i++)
         if (tbl_vld[i] && tbl_age[i] >= 6'd8 && (best < 0 || tbl_age[i] > tbl_age[best])) best = i;
      if (best >= 0) return best;
      for (int i = 0; i < NumEnt; i++)
         if (tbl_vld[i] && is_hit(i)) return i;
      for (int i = 0; i < NumEnt; i++)
         if (tbl_vld[i] && (best < 0 || tbl_age[i] > tbl_age[best])) best = i;
      return best;
   endfunction

   task automatic clear_table();
      for (int i = 0; i < NumEnt; i++) begin
         tbl_ent[i] = '0;
         tbl_age[i] = '0;
      end
      tbl_vld = '0;
   endtask

   task automatic apply_table();
      for (int i = 0; i < NumEnt; i++) begin
         ent_flat[69*i +: 69] = tbl_ent[i];
         age_flat[6*i +: 6]   = tbl_age[i];
      end
      valid_vec = tbl_vld;
   endtask

   task automatic scramble();
      for (int i = 0; i < 23; i++) ent_flat[48*i +: 48] = 48'({$urandom(), $urandom()});
      for (int i = 0; i < 3; i++) age_flat[32*i +: 32] = $urandom();
      valid_vec = 16'($urandom());
   endtask

   task automatic gen_table(input int max_age);
      logic [1:0]  b;
      logic [15:0] r;
      for (int i = 0; i < NumEnt; i++) begin
         b = 2'($urandom());
         if (m_open[b] && $urandom_range(0, 1) == 1) r = m_row[b];
         else r = ($urandom_range(0, 2) == 0) ? 16'($urandom()) : (16'h0012 << $urandom_range(0, 1));
         tbl_ent[i] = mk(2'($urandom()), 1'($urandom()), b, r, 10'($urandom()), $urandom());
         tbl_ent[i][65]    = 1'($urandom());
         tbl_ent[i][64:63] = 2'($urandom());
         tbl_ent[i][34:32] = 3'($urandom());
         tbl_age[i] = 6'($urandom_range(0, max_age));
      end
      tbl_vld = 16'($urandom()) & 16'($urandom());
      if (tbl_vld == '0) tbl_vld[$urandom_range(0, NumEnt - 1)] = 1'b1;
   endtask

   // Called in an idle cycle; returns in the idle cycle after DONE.
   task automatic run_txn(input int d, input logic [31:0] rdv);
      exp_t        ex [64];
      int          sel, t, t_w, rv_cyc, t_done;
      logic [68:0] e;
      logic [1:0]  b;
      logic [15:0] r;
      logic        wr;
      apply_table();
      dram_rdata_valid = 1'($urandom());
      dram_rdata       = $urandom();
      check_cycle('0, 0);
      sel = pick();
      e   = tbl_ent[sel];
      wr  = e[66];
      b   = e[46:45];
      r   = e[62:47];
      for (int k = 0; k < 64; k++) ex[k] = '0;
      t = 1;
      if (m_open[b] && m_row[b] != r) begin
         ex[t].cv = 1'b1; ex[t].cmd = 3'd4; ex[t].bank = b;
         t += TRp;
         m_open[b] = 1'b0;
      end
      if (!m_open[b]) begin
         ex[t].cv = 1'b1; ex[t].cmd = 3'd1; ex[t].bank = b; ex[t].row = r;
         t += TRcd;
         m_open[b] = 1'b1;
         m_row[b]  = r;
      end
      ex[t].cv = 1'b1; ex[t].cmd = wr ? 3'd3 : 3'd2; ex[t].bank = b; ex[t].col = e[44:35];
      ex[t].wd = wr ? e[31:0] : 32'd0;
      t_w    = t + 1;
      rv_cyc = t_w + d;
      t_done = wr ? t_w + TWr : rv_cyc + 1;
      ex[t_done].cc = 1'b1;
      ex[t_done].ce = {e[68:67], e[64:32]};
      if (!wr) begin
         ex[t_done].rv = 1'b1; ex[t_done].rc = e[68:67]; ex[t_done].rd = rdv;
      end
      for (int c = 1; c <= t_done; c++) begin
         @(posedge clk); #1;
         check_cycle(ex[c], c);
         scramble();
         if (!wr && c == rv_cyc) begin
            dram_rdata_valid = 1'b1;
            dram_rdata       = rdv;
         end else begin
            dram_rdata_valid = (!wr && c >= t_w && c < rv_cyc) ? 1'b0 : 1'($urandom());
            dram_rdata       = $urandom();
         end
      end
      @(posedge clk); #1;
      dram_rdata_valid = 1'b0;
      tbl_vld[sel] = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         scramble();
         valid_vec = '0;
         dram_rdata_valid = 1'($urandom());
         check_cycle('0, k);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      exp_t act_e;
      reset = 1'b1;
      ent_flat = '0; valid_vec = '0; age_flat = '0;
      dram_rdata = '0; dram_rdata_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin m_open[i] = 1'b0; m_row[i] = '0; end
      repeat (2) @(posedge clk);
      #1;
      check_cycle('0, -1);
      reset = 1'b0;

      // Read to a closed bank: ACT@1, RD@5, rdata@8, DONE@9.
      clear_table();
      tbl_ent[0] = mk(2'd1, 1'b0, 2'd1, 16'h0012, 10'h055, 32'h0);
      tbl_vld    = 16'h0001;
      run_txn(2, 32'h0000_CAFE);

      // Row hit (entry3, age 2) beats older conflict (entry1, age 5).
      clear_table();
      tbl_ent[1] = mk(2'd0, 1'b0, 2'd1, 16'h0034, 10'h011, 32'h0);
      tbl_ent[3] = mk(2'd3, 1'b0, 2'd1, 16'h0012, 10'h022, 32'h0);
      tbl_age[1] = 6'd5; tbl_age[3] = 6'd2;
      tbl_vld    = 16'h000A;
      run_txn(0, 32'h1111_2222);
      // Remaining conflict: PRE@1, ACT@5, RD@9.
      run_txn(1, 32'h3333_4444);

      // Starving conflict (entry5, age 8) beats a fresh hit (entry2, age 1).
      clear_table();
      tbl_ent[2] = mk(2'd1, 1'b0, 2'd1, 16'h0034, 10'h003, 32'h0);
      tbl_ent[5] = mk(2'd2, 1'b0, 2'd1, 16'h0012, 10'h3FF, 32'h0);
      tbl_age[2] = 6'd1; tbl_age[5] = 6'd8;
      tbl_vld    = 16'h0024;
      run_txn(3, 32'h5555_6666);

      // Write from cpu2 to the open row: WR@1, DONE@8, no response.
      clear_table();
      tbl_ent[0] = mk(2'd2, 1'b1, 2'd1, 16'h0012, 10'h100, 32'h0000_1234);
      tbl_vld    = 16'h0001;
      run_txn(0, 32'h0);

      idle_cycles(3);

      // Reset during ACT aborts, closes every bank, and the entry is re-served from ACT.
      clear_table();
      tbl_ent[4] = mk(2'd3, 1'b0, 2'd2, 16'h0007, 10'h0AA, 32'h0);
      tbl_vld    = 16'h0010;
      apply_table();
      @(posedge clk); #1;
      act_e = '0; act_e.cv = 1'b1; act_e.cmd = 3'd1; act_e.bank = 2'd2; act_e.row = 16'h0007;
      check_cycle(act_e, 1);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      check_cycle('0, 100);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) m_open[i] = 1'b0;
      run_txn(1, 32'h7777_8888);
      // Bank1 row 0x12 was open before reset; it must now need an ACT.
      clear_table();
      tbl_ent[7] = mk(2'd0, 1'b0, 2'd1, 16'h0012, 10'h001, 32'h0);
      tbl_vld    = 16'h0080;
      run_txn(0, 32'h9999_AAAA);

      for (int n = 0; n < 40; n++) begin
         gen_table((n % 2 == 1) ? 15 : 7);
         run_txn($urandom_range(0, 3), $urandom());
         if (n % 10 == 9) idle_cycles(2);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
